// File: rtl/sbox_bijective_lut.sv
// sbox_bijective_lut: loads a 2^DATA_W-entry S-box, checks it is a permutation, builds its inverse and serves lookups
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   load_start_i              abort current activity and begin a new table load
//   load_valid_i, load_data_i next table entry, written at the current load index
//   lk_valid_i, lk_inv_i      lookup request; lk_inv_i selects inverse table
//   lk_addr_i                 lookup address
//   ready_o                   table loaded and bijective
//   load_err_o                sticky duplicate flag for the current load
//   out_valid_o, out_data_o   registered lookup result, one cycle after the request
module sbox_bijective_lut #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              lk_valid_i,
    input  logic              lk_inv_i,
    input  logic [DATA_W-1:0] lk_addr_i,
    output logic              ready_o,
    output logic              load_err_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);
    localparam int DEPTH = 1 << DATA_W;
    localparam int CNT_W = DATA_W + 1;
    typedef enum logic [1:0] {IDLE, LOAD, READY, ERROR} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DEPTH-1:0]  seen_q, seen_d;
    logic              err_q, err_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic              wr, dup, last;
    logic [DATA_W-1:0] fwd [DEPTH];
    logic [DATA_W-1:0] inv [DEPTH];
    assign dup  = seen_q[load_data_i];
    assign last = cnt_q == CNT_W'(DEPTH - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        err_d   = err_q;
        ov_d    = 1'b0;
        od_d    = od_q;
        wr      = 1'b0;
        if (load_start_i) begin
            state_d = LOAD;
            cnt_d   = '0;
            seen_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: if (load_valid_i) begin
                    wr                  = 1'b1;
                    seen_d[load_data_i] = 1'b1;
                    cnt_d               = cnt_q + 1'b1;
                    err_d               = err_q | dup;
                    // the duplicate check includes this final write
                    if (last) state_d = (err_q | dup) ? ERROR : READY;
                end
                READY: if (lk_valid_i) begin
                    ov_d = 1'b1;
                    od_d = lk_inv_i ? inv[lk_addr_i] : fwd[lk_addr_i];
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seen_q  <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end
    // table storage is deliberately not reset; it is only meaningful in READY
    always_ff @(posedge clk) begin
        if (wr && !rst) begin
            fwd[cnt_q[DATA_W-1:0]] <= load_data_i;
            inv[load_data_i]       <= cnt_q[DATA_W-1:0];
        end
    end
    assign ready_o     = state_q == READY;
    assign load_err_o  = err_q;
    assign out_valid_o = ov_q;
    assign out_data_o  = od_q;
endmodule

// File: tb/tb_sbox_bijective_lut.sv
// tb_sbox_bijective_lut: directed self-checking bench for sbox_bijective_lut at DATA_W=8 and DATA_W=4
module tb_sbox_bijective_lut;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ls = 1'b0, lv = 1'b0, kv = 1'b0, ki = 1'b0;
    logic [7:0] ld = '0, ka = '0;
    logic       rdy, err, ov;
    logic [7:0] od;
    logic       ls4 = 1'b0, lv4 = 1'b0, kv4 = 1'b0, ki4 = 1'b0;
    logic [3:0] ld4 = '0, ka4 = '0;
    logic       rdy4, err4, ov4;
    logic [3:0] od4;
    int         n_vec = 0;
    int         n_bad = 0;

    typedef struct packed {
        logic       inv;
        logic [7:0] addr;
        logic [7:0] exp;
    } vec_t;
    vec_t vt [6];

    always #5 clk = ~clk;

    sbox_bijective_lut #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .load_start_i(ls), .load_valid_i(lv), .load_data_i(ld),
        .lk_valid_i(kv), .lk_inv_i(ki), .lk_addr_i(ka), .ready_o(rdy), .load_err_o(err),
        .out_valid_o(ov), .out_data_o(od)
    );

    sbox_bijective_lut #(.DATA_W(4)) dut4 (
        .clk(clk), .rst(rst), .load_start_i(ls4), .load_valid_i(lv4), .load_data_i(ld4),
        .lk_valid_i(kv4), .lk_inv_i(ki4), .lk_addr_i(ka4), .ready_o(rdy4), .load_err_o(err4),
        .out_valid_o(ov4), .out_data_o(od4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_load();
        ls = 1'b1;
        step();
        ls = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        lv = 1'b1;
        ld = d;
        step();
        lv = 1'b0;
    endtask

    task automatic lookup(input logic inv, input logic [7:0] a);
        kv = 1'b1;
        ki = inv;
        ka = a;
        step();
        kv = 1'b0;
    endtask

    initial begin
        vt[0] = '{inv: 1'b0, addr: 8'h00, exp: 8'hFF};
        vt[1] = '{inv: 1'b1, addr: 8'h10, exp: 8'hEF};
        vt[2] = '{inv: 1'b0, addr: 8'h80, exp: 8'h7F};
        vt[3] = '{inv: 1'b1, addr: 8'hFF, exp: 8'h00};
        vt[4] = '{inv: 1'b0, addr: 8'h3C, exp: 8'hC3};
        vt[5] = '{inv: 1'b1, addr: 8'h01, exp: 8'hFE};

        // reset, then lookups in IDLE are ignored
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", rdy, 0);
        chk("rst_err", err, 0);
        chk("rst_ov", ov, 0);
        lookup(1'b0, 8'h00);
        chk("idle_lookup_ov", ov, 0);

        // reversed table, back-to-back writes, lookups attempted during LOAD
        start_load();
        for (int i = 0; i < 256; i++) begin
            kv = (i % 50 == 7);
            wr(8'(255 - i));
            if (i % 50 == 7) chk("load_lookup_ov", ov, 0);
            if (i == 254) chk("ready_before_last", rdy, 0);
        end
        kv = 1'b0;
        chk("rev_ready", rdy, 1);
        chk("rev_err", err, 0);
        for (int v = 0; v < 6; v++) begin
            lookup(vt[v].inv, vt[v].addr);
            chk("vec_ov", ov, 1);
            chk("vec_data", od, vt[v].exp);
        end
        step();
        chk("idle_cycle_ov", ov, 0);
        chk("hold_data", od, 8'hFE);

        // load_start in READY beats a simultaneous lookup
        ls = 1'b1;
        kv = 1'b1;
        step();
        ls = 1'b0;
        kv = 1'b0;
        chk("restart_ready", rdy, 0);
        chk("restart_ov", ov, 0);

        // permutation (7i+3) mod 256 with random gaps
        for (int i = 0; i < 256; i++) begin
            wr(8'((i * 7 + 3) % 256));
            repeat ($urandom_range(0, 2)) step();
        end
        chk("perm_ready", rdy, 1);
        kv = 1'b1;
        ki = 1'b1;
        for (int k = 0; k < 256; k++) begin
            ka = 8'((k * 7 + 3) % 256);
            step();
            chk("stream_ov", ov, 1);
            chk("stream_inv", od, k);
        end
        kv = 1'b0;
        ki = 1'b0;

        // duplicate: entry 200 repeats entry 5 (0x22)
        start_load();
        for (int i = 0; i < 256; i++) begin
            wr((i == 200) ? 8'h22 : 8'((i + 8'h1D) % 256));
            if (i == 199) chk("dup_err_before", err, 0);
            if (i == 200) chk("dup_err_after", err, 1);
        end
        chk("err_state_ready", rdy, 0);
        chk("err_state_err", err, 1);
        lookup(1'b1, 8'h22);
        chk("err_lookup_ov", ov, 0);
        start_load();
        chk("reload_err_clr", err, 0);
        for (int i = 0; i < 256; i++) wr(8'(255 - i));
        chk("reload_ready", rdy, 1);
        chk("reload_err", err, 0);

        // abort after 100 writes; dropped 0xAA must not disturb the fresh load
        start_load();
        for (int i = 0; i < 100; i++) wr(8'(i));
        ls = 1'b1;
        lv = 1'b1;
        ld = 8'hAA;
        step();
        ls = 1'b0;
        lv = 1'b0;
        for (int i = 0; i < 256; i++) begin
            wr(8'(i));
            if (i == 254) chk("abort_ready_early", rdy, 0);
        end
        chk("abort_ready", rdy, 1);
        chk("abort_err", err, 0);
        lookup(1'b0, 8'h00);
        chk("abort_fwd0", od, 8'h00);
        lookup(1'b1, 8'hAA);
        chk("abort_invAA", od, 8'hAA);

        // reset mid-load returns to IDLE
        start_load();
        for (int i = 0; i < 50; i++) wr(8'(i));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", rdy, 0);
        chk("midrst_err", err, 0);
        lookup(1'b0, 8'h01);
        chk("midrst_lookup_ov", ov, 0);
        for (int i = 50; i < 256; i++) wr(8'(i));
        chk("midrst_still_idle", rdy, 0);

        // DATA_W = 4 identity table
        ls4 = 1'b1;
        step();
        ls4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lv4 = 1'b1;
            ld4 = 4'(i);
            step();
            if (i == 14) chk("w4_ready_early", rdy4, 0);
        end
        lv4 = 1'b0;
        chk("w4_ready", rdy4, 1);
        chk("w4_err", err4, 0);
        kv4 = 1'b1;
        ki4 = 1'b0;
        ka4 = 4'hA;
        step();
        chk("w4_fwd_ov", ov4, 1);
        chk("w4_fwd", od4, 4'hA);
        ki4 = 1'b1;
        step();
        chk("w4_inv", od4, 4'hA);
        kv4 = 1'b0;
        step();
        chk("w4_ov_drop", ov4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
